// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: one outstanding CPU load/store to PLIC, GPIO or UART.
// Decodes addr[31:28], waits for the selected slave's ready, and reports data or an error.
//
// Ports
//   clk, rst                     rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata/wstrb  CPU request, sampled only while idle
//   cpu_ready/rdata/err          one-cycle completion pulse with its data and error flag
//   bus_en/we/addr/wdata/wstrb   shared slave bus, held stable while an access is active
//   plic_sel/gpio_sel/uart_sel   one-hot slave selects
//   *_ready, *_rdata             per-slave completion and read data
//   err_addr                     address of the most recent errored access
module periph_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        plic_sel,
    output logic        gpio_sel,
    output logic        uart_sel,
    input  logic        plic_ready,
    input  logic [31:0] plic_rdata,
    input  logic        gpio_ready,
    input  logic [31:0] gpio_rdata,
    input  logic        uart_ready,
    input  logic [31:0] uart_rdata,
    output logic [31:0] err_addr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        R_NONE,
        R_PLIC,
        R_GPIO,
        R_UART
    } region_e;

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic          cpu_ready_q;
    logic [31:0]   cpu_rdata_q;
    logic          cpu_err_q;
    logic          bus_en_q;
    logic          bus_we_q;
    logic [31:0]   bus_addr_q;
    logic [31:0]   bus_wdata_q;
    logic [3:0]    bus_wstrb_q;
    logic          plic_sel_q;
    logic          gpio_sel_q;
    logic          uart_sel_q;
    logic [31:0]   err_addr_q;

    region_e       region_d;
    logic          slv_ready_d;
    logic [31:0]   slv_rdata_d;

    // Region of the incoming request.
    always_comb begin
        region_d = R_NONE;
        unique case (cpu_addr[31:28])
            4'h3:    region_d = R_PLIC;
            4'h4:    region_d = R_GPIO;
            4'h6:    region_d = R_UART;
            default: region_d = R_NONE;
        endcase
    end

    // Only the selected slave is observed; the others may toggle freely.
    always_comb begin
        slv_ready_d = 1'b0;
        slv_rdata_d = '0;
        unique case (1'b1)
            plic_sel_q: begin
                slv_ready_d = plic_ready;
                slv_rdata_d = plic_rdata;
            end
            gpio_sel_q: begin
                slv_ready_d = gpio_ready;
                slv_rdata_d = gpio_rdata;
            end
            uart_sel_q: begin
                slv_ready_d = uart_ready;
                slv_rdata_d = uart_rdata;
            end
            default: begin
                slv_ready_d = 1'b0;
                slv_rdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            plic_sel_q  <= 1'b0;
            gpio_sel_q  <= 1'b0;
            uart_sel_q  <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            // Response outputs are a single-cycle pulse; zero otherwise.
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            cpu_err_q   <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        bus_we_q    <= cpu_we;
                        bus_addr_q  <= cpu_addr;
                        bus_wdata_q <= cpu_wdata;
                        bus_wstrb_q <= cpu_we ? cpu_wstrb : 4'b0000;
                        timer_q     <= '0;
                        if (region_d == R_NONE) begin
                            // Unmapped: answer directly, never touch the bus.
                            state_q     <= S_RESP;
                            cpu_ready_q <= 1'b1;
                            cpu_err_q   <= 1'b1;
                            err_addr_q  <= cpu_addr;
                        end else begin
                            state_q    <= S_ACCESS;
                            bus_en_q   <= 1'b1;
                            plic_sel_q <= (region_d == R_PLIC);
                            gpio_sel_q <= (region_d == R_GPIO);
                            uart_sel_q <= (region_d == R_UART);
                        end
                    end
                end

                S_ACCESS: begin
                    // Ready is checked first so it wins over the timeout.
                    if (slv_ready_d) begin
                        state_q     <= S_RESP;
                        bus_en_q    <= 1'b0;
                        plic_sel_q  <= 1'b0;
                        gpio_sel_q  <= 1'b0;
                        uart_sel_q  <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= bus_we_q ? 32'h0 : slv_rdata_d;
                    end else if (timer_q == TMAX) begin
                        state_q     <= S_RESP;
                        bus_en_q    <= 1'b0;
                        plic_sel_q  <= 1'b0;
                        gpio_sel_q  <= 1'b0;
                        uart_sel_q  <= 1'b0;
                        cpu_ready_q <= 1'b1;
                        cpu_err_q   <= 1'b1;
                        err_addr_q  <= bus_addr_q;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                S_RESP: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign cpu_err   = cpu_err_q;
    assign bus_en    = bus_en_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wstrb = bus_wstrb_q;
    assign plic_sel  = plic_sel_q;
    assign gpio_sel  = gpio_sel_q;
    assign uart_sel  = uart_sel_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Bench for periph_bus_ctrl: fixed vectors, a reset-abort sequence and
// random transactions checked against a transaction-level model.
module tb_periph_bus_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        bus_en;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        plic_sel;
    logic        gpio_sel;
    logic        uart_sel;
    logic        plic_ready;
    logic [31:0] plic_rdata;
    logic        gpio_ready;
    logic [31:0] gpio_rdata;
    logic        uart_ready;
    logic [31:0] uart_rdata;
    logic [31:0] err_addr;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_err_addr;

    periph_bus_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .plic_sel(plic_sel), .gpio_sel(gpio_sel), .uart_sel(uart_sel),
        .plic_ready(plic_ready), .plic_rdata(plic_rdata),
        .gpio_ready(gpio_ready), .gpio_rdata(gpio_rdata),
        .uart_ready(uart_ready), .uart_rdata(uart_rdata),
        .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy_at;
        logic [31:0] sdata;
        int          exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] exp_err_addr;
        int          exp_acc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int region_of(input logic [31:0] a);
        logic [3:0] nib;
        nib = a[31:28];
        case (nib)
            4'h3:    return 1;
            4'h4:    return 2;
            4'h6:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] sel_of(input int r);
        case (r)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic drive_slaves(input int sel, input bit rdy,
                                input logic [31:0] val);
        plic_rdata = $urandom;
        gpio_rdata = $urandom;
        uart_rdata = $urandom;
        plic_ready = (sel == 1) ? rdy : 1'($urandom_range(0, 1));
        gpio_ready = (sel == 2) ? rdy : 1'($urandom_range(0, 1));
        uart_ready = (sel == 3) ? rdy : 1'($urandom_range(0, 1));
        if (rdy) begin
            case (sel)
                1:       plic_rdata = val;
                2:       gpio_rdata = val;
                3:       uart_rdata = val;
                default: ;
            endcase
        end
    endtask

    task automatic quiet_slaves();
        plic_ready = 1'b0;
        gpio_ready = 1'b0;
        uart_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_cpu_ready"}, cpu_ready, 0);
        chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
        chk({tag, "_cpu_err"}, cpu_err, 0);
        chk({tag, "_bus_en"}, bus_en, 0);
        chk({tag, "_bus_we"}, bus_we, 0);
        chk({tag, "_bus_addr"}, bus_addr, 0);
        chk({tag, "_bus_wdata"}, bus_wdata, 0);
        chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
        chk({tag, "_sels"}, {plic_sel, gpio_sel, uart_sel}, 0);
        chk({tag, "_err_addr"}, err_addr, 0);
    endtask

    // Issue one request in the next cycle (cycle N) and follow it to cpu_ready.
    // lat is the cpu_ready cycle relative to N, acc the number of bus_en cycles.
    task automatic run_txn(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           input int rdy_at, input logic [31:0] sdata,
                           output int lat, output logic [31:0] rdata,
                           output logic err, output int acc);
        int r;
        logic [2:0] esel;
        r = region_of(addr);
        esel = sel_of(r);
        lat = -1;
        acc = 0;
        rdata = '0;
        err = 1'b0;
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        cpu_wstrb = wstrb;
        drive_slaves(r, 1'b0, 32'h0);
        for (int c = 1; c <= TO + 4; c++) begin
            @(posedge clk);
            #1;
            if (bus_en) begin
                acc++;
                chk("bus_sel", {plic_sel, gpio_sel, uart_sel}, esel);
                chk("bus_we", bus_we, we);
                chk("bus_addr", bus_addr, addr);
                chk("bus_wdata", bus_wdata, wdata);
                chk("bus_wstrb", bus_wstrb, we ? wstrb : 4'b0);
            end
            if (cpu_ready) begin
                lat = c;
                rdata = cpu_rdata;
                err = cpu_err;
                chk("resp_bus_en", bus_en, 0);
                chk("resp_sels", {plic_sel, gpio_sel, uart_sel}, 0);
                break;
            end
            chk("quiet_rdata", cpu_rdata, 0);
            chk("quiet_err", cpu_err, 0);
            drive_slaves(r, (r != 0) && (c == rdy_at), sdata);
        end
        cpu_req = 1'b0;
        quiet_slaves();
        if (lat < 0) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: no cpu_ready for addr 0x%08h within %0d cycles",
                     addr, TO + 4);
        end
    endtask

    // Transaction-level model: outcome derived from region and ready timing.
    task automatic model(input logic we, input logic [31:0] addr,
                         input int rdy_at, input logic [31:0] sdata,
                         output int lat, output logic err,
                         output logic [31:0] rdata, output int acc);
        if (region_of(addr) == 0) begin
            lat = 1;
            err = 1'b1;
            rdata = 32'h0;
            acc = 0;
            m_err_addr = addr;
        end else if (rdy_at >= 1 && rdy_at <= TO) begin
            lat = rdy_at + 1;
            err = 1'b0;
            rdata = we ? 32'h0 : sdata;
            acc = rdy_at;
        end else begin
            lat = TO + 1;
            err = 1'b1;
            rdata = 32'h0;
            acc = TO;
            m_err_addr = addr;
        end
    endtask

    vec_t tbl[8];

    initial begin
        int lat;
        int acc;
        int e_lat;
        int e_acc;
        logic [31:0] rd;
        logic [31:0] e_rd;
        logic er;
        logic e_er;
        logic [3:0] nib;
        logic [31:0] a;

        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        cpu_wstrb = '0;
        plic_rdata = '0;
        gpio_rdata = '0;
        uart_rdata = '0;
        quiet_slaves();

        tbl[0] = '{1'b0, 32'h4000_0004, 32'h0, 4'h0, 1, 32'hA5A5_0001,
                   2, 1'b0, 32'hA5A5_0001, 32'h0, 1};
        tbl[1] = '{1'b1, 32'h6000_0000, 32'h41, 4'b0001, 3, 32'h0,
                   4, 1'b0, 32'h0, 32'h0, 3};
        tbl[2] = '{1'b0, 32'h2000_0000, 32'h0, 4'h0, 0, 32'h0,
                   1, 1'b1, 32'h0, 32'h2000_0000, 0};
        tbl[3] = '{1'b0, 32'h3000_0010, 32'h0, 4'h0, 0, 32'h0,
                   17, 1'b1, 32'h0, 32'h3000_0010, 16};
        tbl[4] = '{1'b0, 32'h3000_0020, 32'h0, 4'h0, 16, 32'h1234_5678,
                   17, 1'b0, 32'h1234_5678, 32'h3000_0010, 16};
        tbl[5] = '{1'b1, 32'h4000_0008, 32'hCAFE_F00D, 4'b0000, 2, 32'h5555_AAAA,
                   3, 1'b0, 32'h0, 32'h3000_0010, 2};
        tbl[6] = '{1'b0, 32'h7000_0000, 32'h0, 4'h0, 1, 32'h0,
                   1, 1'b1, 32'h0, 32'h7000_0000, 0};
        tbl[7] = '{1'b0, 32'h6000_0004, 32'h0, 4'h0, 15, 32'hDEAD_BEEF,
                   16, 1'b0, 32'hDEAD_BEEF, 32'h7000_0000, 15};

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                    tbl[i].rdy_at, tbl[i].sdata, lat, rd, er, acc);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err_addr", i), err_addr, tbl[i].exp_err_addr);
            chk($sformatf("vec%0d_bus_cycles", i), acc, tbl[i].exp_acc);
        end

        // Reset on the second ACCESS cycle of a UART write.
        @(posedge clk);
        #1;
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 32'h6000_0010;
        cpu_wdata = 32'h0000_0077;
        cpu_wstrb = 4'b0011;
        @(posedge clk);
        #1;
        chk("rstseq_acc1_bus_en", bus_en, 1);
        chk("rstseq_acc1_uart_sel", uart_sel, 1);
        @(posedge clk);
        #1;
        chk("rstseq_acc2_bus_en", bus_en, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("rstseq");
        rst = 1'b0;
        cpu_req = 1'b0;
        m_err_addr = 32'h0;
        run_txn(1'b0, 32'h4000_0100, 32'h0, 4'h0, 1, 32'h0BAD_F00D,
                lat, rd, er, acc);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_rdata", rd, 32'h0BAD_F00D);
        chk("post_rst_err", er, 0);
        chk("post_rst_err_addr", err_addr, 0);

        for (int i = 0; i < 40; i++) begin
            logic we;
            logic [3:0] ws;
            logic [31:0] wd;
            logic [31:0] sd;
            int ra;
            case ($urandom_range(0, 3))
                0:       nib = 4'h3;
                1:       nib = 4'h4;
                2:       nib = 4'h6;
                default: begin
                    nib = 4'($urandom_range(0, 15));
                    if (nib == 4'h3 || nib == 4'h4 || nib == 4'h6)
                        nib = 4'h9;
                end
            endcase
            a = {nib, 28'($urandom)};
            we = 1'($urandom_range(0, 1));
            ws = 4'($urandom_range(0, 15));
            wd = $urandom;
            sd = $urandom;
            ra = $urandom_range(0, TO + 2);
            model(we, a, ra, sd, e_lat, e_er, e_rd, e_acc);
            run_txn(we, a, wd, ws, ra, sd, lat, rd, er, acc);
            chk($sformatf("rnd%0d_latency", i), lat, e_lat);
            chk($sformatf("rnd%0d_err", i), er, e_er);
            chk($sformatf("rnd%0d_rdata", i), rd, e_rd);
            chk($sformatf("rnd%0d_err_addr", i), err_addr, m_err_addr);
            chk($sformatf("rnd%0d_bus_cycles", i), acc, e_acc);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
